// File: rtl/adder_pkg.sv
// Shared constants, response-register state type and index-width helper for the
// round-robin adder scheduler.
package adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SWIDTH = DEF_WIDTH + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_sched_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or above ptr,
// wrapping from NREQ-1 to 0; en gates the one-hot grant and gnt_any.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  logic [IDW-1:0] cand;
  logic [IDW-1:0] win_idx;
  logic           found;

  always_comb begin
    cand    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign gnt_idx = win_idx;
  assign gnt_any = en & found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : gen_onehot
    assign gnt_onehot[gi] = gnt_any && (win_idx == IDW'(gi));
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one WIDTH-bit adder among NREQ requesters in round-robin order with a
// registered, tagged response. Define ADDER_RR_SCHED_STATS_EN for per-requester grant counters.
module adder_rr_sched
  import adder_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int IDW    = idx_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [SWIDTH-1:0]     rsp_sum,
  output logic                  rsp_zero,
  output logic                  busy
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]    grant_cnt
`endif
);

  rsp_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [SWIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              can_accept;
  logic              arb_en;
  logic [NREQ-1:0]   gnt_onehot;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;

  logic [WIDTH-1:0]  x_arr [NREQ];
  logic [WIDTH-1:0]  y_arr [NREQ];
  logic [WIDTH-1:0]  x_sel, y_sel;
  logic              cin_sel;
  logic [SWIDTH-1:0] sum_w;

  for (genvar gi = 0; gi < NREQ; gi++) begin : gen_unpack
    assign x_arr[gi] = req_x[gi*WIDTH +: WIDTH];
    assign y_arr[gi] = req_y[gi*WIDTH +: WIDTH];
  end

  // A full register can still take a new result in the cycle it drains.
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign arb_en     = can_accept & rst_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .en         (arb_en),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign req_ready = gnt_onehot;

  assign x_sel   = x_arr[gnt_idx];
  assign y_sel   = y_arr[gnt_idx];
  assign cin_sel = req_cin[gnt_idx];
  assign sum_w   = SWIDTH'(x_sel) + SWIDTH'(y_sel) + SWIDTH'(cin_sel);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_zero_d = rsp_zero_q;
    if (gnt_any) begin
      state_d    = FULL;
      ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      rsp_id_d   = gnt_idx;
      rsp_sum_d  = sum_w;
      rsp_zero_d = (sum_w == '0);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = rsp_valid | (|req_valid);

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [15:0] cnt_q [NREQ];

  // A one-hot grant bit is only raised on an actual transfer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : gen_stats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[gi] <= '0;
      end else if (gnt_onehot[gi]) begin
        cnt_q[gi] <= cnt_q[gi] + 16'd1;
      end
    end
    assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed and randomized checks of adder_rr_sched against a round-robin reference model.
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic              rsp_zero;
  logic              busy;
`ifdef ADDER_RR_SCHED_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  adder_rr_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
`ifdef ADDER_RR_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_full;
  int m_ptr, m_id, m_sum, m_g;
  bit m_zero, m_xfer;
  int m_cnt [NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_zero = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input int x, input int y, input bit c);
    req_valid[i]       = v;
    req_x[i*W +: W]    = W'(x);
    req_y[i*W +: W]    = W'(y);
    req_cin[i]         = c;
  endtask

  task automatic rand_ops(input int i, input bit v);
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0)      set_req(i, v, 0, 0, 1'b0);
    else if (sel == 1) set_req(i, v, 255, 255, 1'b1);
    else set_req(i, v, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endtask

  // One clock: combinational checks at the falling edge, registered checks just after the rising edge.
  task automatic do_cycle();
    int  g;
    bit  can;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    can     = !m_full || rsp_ready;
    g       = model_grant();
    exp_rdy = (can && g >= 0) ? NREQ'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_full || (req_valid != 0)));
    m_xfer = can && (g >= 0);
    m_g    = g;
    @(posedge clk);
    if (m_xfer) begin
      m_sum  = int'(req_x[g*W +: W]) + int'(req_y[g*W +: W]) + int'(req_cin[g]);
      m_zero = (m_sum == 0);
      m_id   = g;
      m_full = 1;
      m_ptr  = (g + 1) % NREQ;
      m_cnt[g] = (m_cnt[g] + 1) % 65536;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
    check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
`ifdef ADDER_RR_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    $display("cycle t=%0t xfer=%0b g=%0d rsp_valid=%0b id=%0d sum=%0h", $time, m_xfer, m_g, rsp_valid, rsp_id, rsp_sum);
  endtask

  task automatic hard_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    req_valid = '1; req_x = '0; req_y = '0; req_cin = '0; rsp_ready = 1'b1;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset state while every requester is asking
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin over four always-valid requesters
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b1);
    for (int k = 0; k < 8; k++) begin
      do_cycle();
      check("rr_seq_id", 32'(rsp_id), 32'(k % NREQ));
      check("rr_seq_valid", 32'(rsp_valid), 32'd1);
      rand_ops(m_g, 1'b1);
    end

    // Arithmetic corners
    req_valid = '0;
    set_req(2, 1'b1, 255, 255, 1'b1);
    do_cycle();
    check("max_sum", 32'(rsp_sum), 32'h1FF);
    check("max_zero", 32'(rsp_zero), 32'd0);
    req_valid[2] = 1'b0;
    set_req(1, 1'b1, 0, 0, 1'b0);
    do_cycle();
    check("zero_sum", 32'(rsp_sum), 32'd0);
    check("zero_flag", 32'(rsp_zero), 32'd1);

    // Back-pressure: full register, consumer stalled for three cycles
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b1);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_sum", 32'(rsp_sum), 32'd0);
    end
    rsp_ready = 1'b1;
    do_cycle();
    check("bp_refill_id", 32'(rsp_id), 32'd2);
    check("bp_refill_valid", 32'(rsp_valid), 32'd1);
    req_valid = '0;
    do_cycle();
    check("drained", 32'(rsp_valid), 32'd0);

    // Fairness with gaps
    rand_ops(3, 1'b1);
    do_cycle();
    check("gap_id3", 32'(rsp_id), 32'd3);
    rand_ops(0, 1'b1);
    rand_ops(3, 1'b1);
    do_cycle();
    check("gap_id0", 32'(rsp_id), 32'd0);
    req_valid[0] = 1'b0;
    do_cycle();
    check("gap_id3_again", 32'(rsp_id), 32'd3);
    req_valid = '0;

    // Randomized traffic; requesters hold until accepted
    for (int k = 0; k < 400; k++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      do_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (m_xfer && i == m_g) rand_ops(i, 1'($urandom_range(0, 1)));
        else if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_ops(i, 1'b1);
      end
    end

    // Reset in the middle of traffic
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b1);
    hard_reset();
    rsp_ready = 1'b1;
    do_cycle();
    check("post_rst_id", 32'(rsp_id), 32'd0);

`ifdef ADDER_RR_SCHED_STATS_EN
    hard_reset();
    req_valid = '0;
    rand_ops(1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      do_cycle();
      rand_ops(1, 1'b1);
    end
    check("stats_cnt1", 32'(grant_cnt[31:16]), 32'd5);
    check("stats_cnt0", 32'(grant_cnt[15:0]), 32'd0);
    check("stats_cnt23", 32'(grant_cnt[63:32]), 32'd0);
    while (m_cnt[1] != 16'hFFFF) do_cycle();
    check("stats_ffff", 32'(grant_cnt[31:16]), 32'hFFFF);
    do_cycle();
    check("stats_wrap", 32'(grant_cnt[31:16]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
- Shares one WIDTH-bit adder among NREQ requesters, granting them in round-robin order.
- Each requester presents an operand pair (x, y, cin) on a valid/ready handshake. The sum is registered and returned on a response channel tagged with the requester index.
- Sits between client blocks and the adder datapath. It replaces per-client adders where throughput of one add per cycle in aggregate is enough.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand width.
- SWIDTH, WIDTH+1, sum width (includes carry-out).
- IDW, $clog2(NREQ), width of the requester index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle.
- req_x  in  NREQ*WIDTH  packed x operands; requester i occupies [i*WIDTH +: WIDTH].
- req_y  in  NREQ*WIDTH  packed y operands, same packing as req_x.
- req_cin  in  NREQ  per-requester carry-in.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that produced the result.
- rsp_sum  out  SWIDTH  x + y + cin, zero-extended to SWIDTH bits.
- rsp_zero  out  1  high when rsp_sum == 0.
- busy  out  1  high when rsp_valid is high or any req_valid bit is high.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_zero=0, round-robin pointer=0, state=EMPTY. With rst_n low, req_ready=0.
- State machine (response register):
  - EMPTY: can_accept=1.
  - FULL, rsp_ready=1: can_accept=1 (drain and refill in the same cycle).
  - FULL, rsp_ready=0: can_accept=0; all response outputs hold stable.
- Arbitration:
  - Grant goes to the first asserted req_valid bit at or after the pointer, searching upward with wrap from NREQ-1 to 0.
  - req_ready is one-hot, at the granted bit only, and only when can_accept=1. It is combinational from req_valid, pointer, state and rsp_ready; there is no path from req_x or req_y.
- Transfer: happens when req_valid[g] and req_ready[g] are both high. On that edge:
  - rsp_sum <= x[g] + y[g] + cin[g], computed at SWIDTH bits.
  - rsp_zero <= (that sum == 0).
  - rsp_id <= g; rsp_valid <= 1; state <= FULL.
  - pointer <= (g+1) mod NREQ.
- Response drain without a new transfer: rsp_valid <= 0, state <= EMPTY. rsp_sum and rsp_id keep their last values.
- Latency and throughput: the response appears 1 cycle after the transfer. Sustained throughput is 1 add per cycle while rsp_ready stays high.
- Pointer updates only on a transfer. Idle cycles or back-pressure leave it unchanged, so no requester starves.
- Stability rule: a requester must hold valid and its operands until accepted. The block does not check this.
- Single requester: it is granted every cycle that can_accept=1.
- Overflow: the maximum sum, 2^(WIDTH+1)-1, fits in SWIDTH bits; there is no saturation.
- Reset mid-operation: any in-flight response is discarded and the pointer returns to 0.

Optional Feature:
- Macro: ADDER_RR_SCHED_STATS_EN.
- Enabled: adds output grant_cnt, width NREQ*16. It holds per-requester 16-bit transfer counters that increment on each transfer, wrap at 0xFFFF->0, and reset to 0.
- Disabled: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg holds:
  - the default WIDTH and SWIDTH constants;
  - the state enum {EMPTY, FULL};
  - the function that computes an index width from NREQ.
- One sub-module, rr_arbiter (params NREQ, IDW):
  - inputs req, en, ptr;
  - outputs gnt_onehot, gnt_idx, gnt_any.
- The scheduler keeps the pointer, state, adder and response register.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111. Expect req_ready=0 and rsp_valid=0. After release, the first grant is to id 0.
- Round-robin: all four requesters valid, rsp_ready=1, 8 cycles. Expect rsp_id sequence 0,1,2,3,0,1,2,3 and one response per cycle.
- Arithmetic: WIDTH=8.
  - req2 with x=0xFF, y=0xFF, cin=1 gives rsp_sum=0x1FF, rsp_zero=0.
  - req1 with x=0, y=0, cin=0 gives rsp_sum=0, rsp_zero=1.
- Back-pressure: hold rsp_ready=0 for 3 cycles while FULL. Expect req_ready=0, rsp outputs stable, pointer unchanged. When rsp_ready=1, drain and refill happen in the same cycle.
- Fairness with gaps: only req3 valid. It is granted and the pointer goes to 0. Then req0 and req3 are both valid: req0 is granted first, then req3.
- STATS_EN build: issue 5 transfers from req1. Expect grant_cnt[1]=5 and all other counters 0. Preload a counter to 0xFFFF and issue one more transfer; it wraps to 0.
